// File: rtl/demux_pkg.sv
// Shared constants and channel state encoding for the 1-to-4 handshake demux.
package demux_pkg;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;
endpackage

// File: rtl/demux_slot.sv
// One-entry register slice for a single output channel: loads on accept, empties on drain.
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  ch_state_e    r_state;
  ch_state_e    w_state_nxt;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // A load while FULL is only issued when the consumer drains the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (i_load) w_state_nxt = FULL;
      FULL:    if (!i_load && i_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Payload is kept after drain; only a new load or reset changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_data <= '0;
    else if (i_load) r_data <= i_data;
  end

  assign o_valid = (r_state == FULL);
  assign o_data  = r_data;

endmodule

// File: rtl/demux1x4_hs.sv
// 1-to-4 valid/ready demultiplexer with a one-entry slice per channel and a transfer counter.
module demux1x4_hs
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SEL_W-1:0]   s_sel,
  input  logic [W-1:0]       s_data,
  output logic [NCH-1:0]     m_valid,
  input  logic [NCH-1:0]     m_ready,
  output logic [NCH*W-1:0]   m_data,
  output logic [CNT_W-1:0]   xfer_cnt,
  output logic               busy
);

  logic             w_accept;
  logic [NCH-1:0]   w_load;
  logic [CNT_W-1:0] r_cnt;

  // Ready depends only on the selected channel, so a stalled channel never blocks others.
  assign s_ready  = ~m_valid[s_sel] | m_ready[s_sel];
  assign w_accept = s_valid & s_ready;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_load[g] = w_accept & (s_sel == SEL_W'(g));

    demux_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[g]),
      .i_data  (s_data),
      .i_ready (m_ready[g]),
      .o_valid (m_valid[g]),
      .o_data  (m_data[g*W +: W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (w_accept) r_cnt <= r_cnt + 1'b1;
  end

  assign xfer_cnt = r_cnt;
  assign busy     = |m_valid;

endmodule

// File: tb/tb_demux1x4_hs.sv
// Randomized and directed bench for demux1x4_hs against a per-channel queue model.
module tb_demux1x4_hs;
  localparam int W   = 8;
  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [1:0]       s_sel;
  logic [W-1:0]     s_data;
  logic [NCH-1:0]   m_valid;
  logic [NCH-1:0]   m_ready;
  logic [NCH*W-1:0] m_data;
  logic [15:0]      xfer_cnt;
  logic             busy;

  demux1x4_hs #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sel    (s_sel),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .xfer_cnt (xfer_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: each channel is a FIFO of accepted payloads, plus last-loaded payload per channel.
  logic [W-1:0] exp_q [NCH][$];
  logic [W-1:0] last_d [NCH];
  int           exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      exp_q[k].delete();
      last_d[k] = '0;
    end
    exp_cnt = 0;
  endtask

  function automatic logic mvalid_exp(input int k);
    return exp_q[k].size() != 0;
  endfunction

  task automatic check_model();
    logic any;
    any = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("m_valid[%0d]", k), 32'(m_valid[k]), 32'(mvalid_exp(k)));
      chk($sformatf("m_data[%0d]", k), 32'(m_data[k*W +: W]),
          mvalid_exp(k) ? 32'(exp_q[k][0]) : 32'(last_d[k]));
      any |= mvalid_exp(k);
    end
    chk("s_ready", 32'(s_ready), 32'(!mvalid_exp(int'(s_sel)) || m_ready[s_sel]));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt[15:0]));
    chk("busy", 32'(busy), 32'(any));
  endtask

  // Drive one cycle from a negedge, check, then advance the model across the posedge.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                       input logic [NCH-1:0] mr);
    logic acc;
    s_valid = v; s_sel = sel; s_data = d; m_ready = mr;
    #1;
    check_model();
    acc = v && (!mvalid_exp(int'(sel)) || mr[sel]);
    @(posedge clk);
    for (int k = 0; k < NCH; k++)
      if (mvalid_exp(k) && mr[k]) void'(exp_q[k].pop_front());
    if (acc) begin
      exp_q[sel].push_back(d);
      last_d[sel] = d;
      exp_cnt = (exp_cnt + 1) & 32'hFFFF;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_valid = 0; s_sel = 0; s_data = 0; m_ready = 0;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    s_valid = 0; s_sel = 0; s_data = 0; m_ready = 0;
    model_clear();
    #2;
    do_reset();

    // First-edge accept into channel 2.
    cycle(1, 2'd2, 8'hA5, 4'h0);
    chk("t028_m_valid", 32'(m_valid), 32'h4);
    chk("t028_m_data2", 32'(m_data[23:16]), 32'hA5);
    chk("t028_cnt", 32'(xfer_cnt), 32'd1);

    // Stalled channel 1 refuses, channel 3 still loads.
    cycle(1, 2'd1, 8'h5A, 4'h0);
    s_valid = 1; s_sel = 2'd1; s_data = 8'h77; m_ready = 4'h0;
    #1;
    chk("t029_rdy_ch1", 32'(s_ready), 32'h0);
    cycle(1, 2'd3, 8'h3C, 4'h0);
    chk("t029_m_valid", 32'(m_valid), 32'hE);
    chk("t029_data1", 32'(m_data[15:8]), 32'h5A);
    chk("t029_data3", 32'(m_data[31:24]), 32'h3C);

    // Simultaneous drain and refill on channel 0, no bubble.
    cycle(1, 2'd0, 8'h11, 4'h0);
    cycle(1, 2'd0, 8'h22, 4'h1);
    chk("t030_valid0", 32'(m_valid[0]), 32'h1);
    chk("t030_data0", 32'(m_data[7:0]), 32'h22);

    // Drain channel 0 then idle ready on empty channel: data retained.
    cycle(0, 2'd0, 8'h00, 4'h1);
    cycle(0, 2'd0, 8'h00, 4'h1);
    chk("t019_valid0", 32'(m_valid[0]), 32'h0);
    chk("t019_data0", 32'(m_data[7:0]), 32'h22);

    // All channels full, then asynchronous reset mid-cycle.
    cycle(1, 2'd0, 8'h99, 4'h0);
    chk("t032_full", 32'(m_valid), 32'hF);
    s_valid = 0; m_ready = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("t032_m_valid", 32'(m_valid), 32'h0);
    chk("t032_cnt", 32'(xfer_cnt), 32'h0);
    chk("t032_data", m_data, 32'h0);
    for (int s = 0; s < NCH; s++) begin
      s_sel = 2'(s);
      #1;
      chk($sformatf("t032_rdy%0d", s), 32'(s_ready), 32'h1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 2'd1, 8'h42, 4'h0);
    chk("t025_first", 32'(m_valid), 32'h2);

    // Random traffic against the queue model.
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
    for (int i = 0; i < 2; i++) cycle(0, 2'd0, 8'h0, 4'hF);
    chk("rand_empty", 32'(m_valid), 32'h0);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 65534; i++) cycle(1, 2'd0, 8'(i), 4'hF);
    chk("t031_fffe", 32'(xfer_cnt), 32'hFFFE);
    cycle(1, 2'd0, 8'hAB, 4'hF);
    chk("t031_ffff", 32'(xfer_cnt), 32'hFFFF);
    cycle(1, 2'd0, 8'hCD, 4'hF);
    chk("t031_0000", 32'(xfer_cnt), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
